// File: rtl/conv_ctrl_pkg.sv
// Shared constants, instruction field positions and FSM state set for the
// convolution tile sequencer.
package conv_ctrl_pkg;

  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int LEN_KIJ  = 9;
  localparam int KER_W    = 3;
  localparam int IN_W     = 6;
  localparam int OUT_W    = 4;
  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int GAP      = 10;
  localparam int RST_CYC  = 10;
  localparam int W_BASE   = 1024;

  localparam int INST_W = 35;
  localparam int ADDR_W = 11;

  localparam int B_RELU     = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both memories disabled and in read mode; every other field low.
  localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_W2L0,
    S_G1,
    S_LOAD,
    S_G2,
    S_X2L0,
    S_G3,
    S_EXEC,
    S_DRAIN,
    S_OFRD,
    S_ACLR,
    S_ARD,
    S_ATAIL,
    S_RELU,
    S_DONE
  } state_t;

  // Fixed dwell time of each counted state; OFRD is data-driven and IDLE waits.
  function automatic logic [5:0] state_len(input state_t s);
    case (s)
      S_CLR:                 state_len = 6'(RST_CYC);
      S_W2L0, S_LOAD:        state_len = 6'(COL);
      S_G1, S_G2, S_G3:      state_len = 6'(GAP);
      S_X2L0, S_EXEC:        state_len = 6'(LEN_NIJ);
      S_DRAIN:               state_len = 6'(ROW + COL);
      S_ARD:                 state_len = 6'(LEN_KIJ);
      default:               state_len = 6'd1;
    endcase
  endfunction

  function automatic state_t state_after(input state_t s);
    case (s)
      S_CLR:   state_after = S_W2L0;
      S_W2L0:  state_after = S_G1;
      S_G1:    state_after = S_LOAD;
      S_LOAD:  state_after = S_G2;
      S_G2:    state_after = S_X2L0;
      S_X2L0:  state_after = S_G3;
      S_G3:    state_after = S_EXEC;
      S_EXEC:  state_after = S_DRAIN;
      S_DRAIN: state_after = S_OFRD;
      S_ACLR:  state_after = S_ARD;
      S_ARD:   state_after = S_ATAIL;
      S_ATAIL: state_after = S_RELU;
      default: state_after = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Address generation for the sequencer: xmem weight/activation addresses,
// pmem partial-sum write addresses and the accumulation tap address.
module conv_addr_gen
  import conv_ctrl_pkg::*;
(
  input  state_t             st_i,
  input  logic [5:0]         idx_i,
  input  logic [3:0]         kij_i,
  input  logic [4:0]         onij_i,
  input  logic [5:0]         n_i,
  input  logic               xfer_i,
  output logic [ADDR_W-1:0]  a_xmem_o,
  output logic [ADDR_W-1:0]  a_pmem_o
);

  logic [5:0]        k_div;
  logic [5:0]        k_mod;
  logic [4:0]        o_div;
  logic [4:0]        o_mod;
  logic [ADDR_W-1:0] tap_addr;

  // Tap k of output pixel o lives in the k-th partial-sum plane, shifted by
  // the kernel offset inside the input feature map.
  assign k_div    = idx_i / 6'(KER_W);
  assign k_mod    = idx_i % 6'(KER_W);
  assign o_div    = onij_i / 5'(OUT_W);
  assign o_mod    = onij_i % 5'(OUT_W);
  assign tap_addr = 11'(idx_i) * 11'(LEN_NIJ)
                  + (11'(o_div) + 11'(k_div)) * 11'(IN_W)
                  + 11'(o_mod) + 11'(k_mod);

  always_comb begin
    a_xmem_o = '0;
    a_pmem_o = '0;
    case (st_i)
      S_W2L0:  a_xmem_o = 11'(W_BASE) + 11'(kij_i) * 11'(COL) + 11'(idx_i);
      S_X2L0:  a_xmem_o = 11'(idx_i);
      S_OFRD:  if (xfer_i) a_pmem_o = 11'(kij_i) * 11'(LEN_NIJ) + 11'(n_i);
      S_ARD:   a_pmem_o = tap_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Tile sequencer: walks all kernel taps through the core, then runs the
// accumulate/ReLU pass. Outputs are registered from the next-state decode.
module conv_seq_ctrl
  import conv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx,
  output logic [4:0]        onij_idx
);

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [3:0]        kij_q, kij_d;
  logic [4:0]        onij_q, onij_d;
  logic [5:0]        n_q, n_d;
  logic              xfer;
  logic              last;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] a_xmem;
  logic [ADDR_W-1:0] a_pmem;

  assign last = (cnt_q == state_len(state_q) - 6'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kij_d   = kij_q;
    onij_d  = onij_q;
    n_d     = n_q;
    xfer    = 1'b0;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      kij_d   = '0;
      onij_d  = '0;
      n_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CLR;
            cnt_d   = '0;
            kij_d   = '0;
            onij_d  = '0;
          end
        end
        S_OFRD: begin
          if (n_q == 6'(LEN_NIJ)) begin
            cnt_d = '0;
            n_d   = '0;
            if (kij_q == 4'(LEN_KIJ - 1)) begin
              state_d = S_ACLR;
              onij_d  = '0;
            end else begin
              state_d = S_CLR;
              kij_d   = kij_q + 4'd1;
            end
          end else if (ofifo_valid) begin
            xfer = 1'b1;
            n_d  = n_q + 6'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          if (last) begin
            cnt_d   = '0;
            state_d = state_after(state_q);
            if (state_q == S_DRAIN && ofifo_valid) begin
              xfer = 1'b1;
              n_d  = 6'd1;
            end
            if (state_q == S_RELU) begin
              if (onij_q == 5'(LEN_ONIJ - 1)) begin
                state_d = S_DONE;
              end else begin
                state_d = S_ACLR;
                onij_d  = onij_q + 5'd1;
              end
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      endcase
    end
  end

  conv_addr_gen u_addr_gen (
    .st_i     (state_d),
    .idx_i    (cnt_d),
    .kij_i    (kij_d),
    .onij_i   (onij_d),
    .n_i      (n_q),
    .xfer_i   (xfer),
    .a_xmem_o (a_xmem),
    .a_pmem_o (a_pmem)
  );

  always_comb begin
    inst_d             = INST_IDLE;
    inst_d[B_IFIFO_WR] = 1'b0;
    inst_d[B_IFIFO_RD] = 1'b0;
    core_rst_d         = 1'b0;
    done_d             = 1'b0;
    case (state_d)
      S_CLR, S_ACLR: core_rst_d = 1'b1;
      S_W2L0, S_X2L0: begin
        inst_d[B_CEN_X]               = 1'b0;
        inst_d[B_L0_WR]               = 1'b1;
        inst_d[B_AX_LSB +: ADDR_W]    = a_xmem;
      end
      S_LOAD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
      end
      S_EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
      end
      S_OFRD: begin
        if (xfer) begin
          inst_d[B_OFIFO_RD]         = 1'b1;
          inst_d[B_CEN_P]            = 1'b0;
          inst_d[B_WEN_P]            = 1'b0;
          inst_d[B_AP_LSB +: ADDR_W] = a_pmem;
        end
      end
      S_ARD: begin
        // acc trails the first read by one cycle to cover pmem read latency.
        inst_d[B_CEN_P]            = 1'b0;
        inst_d[B_AP_LSB +: ADDR_W] = a_pmem;
        inst_d[B_ACC]              = (cnt_d != 6'd0);
      end
      S_ATAIL: inst_d[B_ACC]  = 1'b1;
      S_RELU:  inst_d[B_RELU] = 1'b1;
      S_DONE:  done_d         = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kij_q      <= '0;
      onij_q     <= '0;
      n_q        <= '0;
      inst_q     <= INST_IDLE;
      core_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kij_q      <= kij_d;
      onij_q     <= onij_d;
      n_q        <= n_d;
      inst_q     <= inst_d;
      core_rst_q <= core_rst_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= done_d;
    end
  end

  assign inst     = inst_q;
  assign core_rst = core_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign kij_idx  = kij_q;
  assign onij_idx = onij_q;

endmodule
